cache_port_arbiter: RTL
=======================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter FULL_WIDTH, default 18, byte-address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-004 Clocking: one clock; reset is synchronous and active-high; ports clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 p0_req, p1_req  in  1  request from port n; held with payload until granted.
REQ-008 p0_wren, p1_wren  in  1  1 = write, 0 = read.
REQ-009 p0_addr, p1_addr  in  FULL_WIDTH  byte address.
REQ-010 p0_din, p1_din  in  MEM_WIDTH  write data.
REQ-011 p0_gnt, p1_gnt  out  1  one-cycle grant pulse; payload is sampled on this cycle.
REQ-012 p0_done, p1_done  out  1  one-cycle completion pulse.
REQ-013 p0_q, p1_q  out  MEM_WIDTH  read data, valid from done and held until that port's next done.
REQ-014 c_address  out  FULL_WIDTH; c_din  out  MEM_WIDTH; c_rden, c_wren  out  1 -- cache request.
REQ-015 c_q  in  MEM_WIDTH; c_hit_miss  in  1; c_idle  in  1, high while the cache FSM is in IDLE.
REQ-016 stat_clr  in  1; hit_cnt, miss_cnt  out  CNT_WIDTH.

Function
REQ-017 FSM states SHALL be ARB, ISSUE, BUSY.
REQ-018 ARB: if any req is high, SHALL assert exactly one gnt, latch that port's wren/addr/din and owner id, and go to ISSUE. Otherwise it SHALL stay in ARB.
REQ-019 Arbitration SHALL be round-robin: with both requests high, the port not granted last wins. The pointer after reset SHALL favour port 0.
REQ-020 ISSUE (exactly 1 cycle): SHALL drive c_address/c_din from the latched values, with c_wren = latched wren and c_rden = !latched wren, then go to BUSY.
REQ-021 c_rden and c_wren SHALL be low in every state except ISSUE and SHALL never be high together.
REQ-022 BUSY: SHALL wait until c_idle = 1. On that edge it SHALL register c_q into the owner's q (reads only), pulse the owner's done for 1 cycle, and return to ARB.
REQ-023 The first BUSY cycle SHALL ignore c_idle, because the cache always leaves IDLE after a request.
REQ-024 A new grant SHALL be permitted in the same cycle as the previous done.
REQ-025 Latency for a cache hit SHALL be: gnt at T, ISSUE at T+1, done at T+4. Latency for a miss SHALL be variable and bounded only by the cache.
REQ-026 Write completion SHALL pulse done and leave p_q unchanged.
REQ-027 In the ISSUE cycle, c_hit_miss = 1 SHALL increment hit_cnt; otherwise miss_cnt SHALL increment.
REQ-028 Both counters SHALL saturate at all-ones.
REQ-029 stat_clr SHALL zero both counters and SHALL override a same-cycle increment.
REQ-030 A req that drops before gnt SHALL be treated as withdrawn. A req held after its own done SHALL be eligible again under round-robin.

Reset
REQ-031 On rst, the block SHALL enter ARB.
REQ-032 On rst, all gnt, done, c_rden and c_wren SHALL be 0; c_address, c_din, p0_q, p1_q, hit_cnt and miss_cnt SHALL be 0; the round-robin pointer SHALL favour port 0.
REQ-033 rst mid-transaction SHALL abandon the transaction with no done.

Structure
REQ-034 A shared package cache_pkg SHALL hold MEM_WIDTH/FULL_WIDTH defaults and the arbiter state enum.
REQ-035 A sub-module rr_pick2 SHALL implement the 2-way round-robin selection and pointer.

Verification
REQ-036 Both ports idle after reset, then p0 read hit at 0x00010 -> p0_gnt at T, c_rden only at T+1, p0_done at T+4, p0_q = cached word, hit_cnt = 1.
REQ-037 p0 and p1 req in the same cycle, held -> grant order p0, p1, p0; never two gnt in one cycle.
REQ-038 p1 write 0xDEADBEEF to a clean-miss address -> single c_wren pulse, p1_done after c_idle returns, miss_cnt = 1, p1_q unchanged.
REQ-039 Force hit_cnt to all-ones then issue a hit -> hit_cnt stays all-ones; stat_clr concurrent with an ISSUE -> hit_cnt = miss_cnt = 0.
REQ-040 rst asserted during BUSY of a dirty miss -> no done; ARB on the next cycle with all outputs 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache port arbiter: default widths and FSM states.
package cache_pkg;

  localparam int MEM_WIDTH_DEF  = 32;
  localparam int FULL_WIDTH_DEF = 18;

  // ARB picks a port, ISSUE drives the cache for one cycle, BUSY waits for it.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. The pointer names the port favoured on a tie
// and flips to the other port after every grant.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 favours port 0, 1 favours port 1
  logic prio_reg;

  // Grant selection: tie broken by the pointer, single requester wins outright
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = prio_reg ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer update: after granting port 0, favour port 1, and vice versa
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (|gnt) begin
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port front end for a single-ported cache: round-robin grant, one-cycle
// cache command, wait for the cache to return to idle, then per-port done.
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int FULL_WIDTH = FULL_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_wren,
  input  logic [FULL_WIDTH-1:0] p0_addr,
  input  logic [MEM_WIDTH-1:0]  p0_din,
  input  logic                  p1_req,
  input  logic                  p1_wren,
  input  logic [FULL_WIDTH-1:0] p1_addr,
  input  logic [MEM_WIDTH-1:0]  p1_din,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_done,
  output logic                  p1_done,
  output logic [MEM_WIDTH-1:0]  p0_q,
  output logic [MEM_WIDTH-1:0]  p1_q,
  output logic [FULL_WIDTH-1:0] c_address,
  output logic [MEM_WIDTH-1:0]  c_din,
  output logic                  c_rden,
  output logic                  c_wren,
  input  logic [MEM_WIDTH-1:0]  c_q,
  input  logic                  c_hit_miss,
  input  logic                  c_idle,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  arb_state_t             state_reg, state_next;
  logic [1:0]             gnt;
  logic                   owner_reg;
  logic                   wren_reg;
  logic [FULL_WIDTH-1:0]  addr_reg;
  logic [MEM_WIDTH-1:0]   din_reg;
  logic                   first_reg;
  logic                   complete;
  logic                   done_reg [2];
  logic [MEM_WIDTH-1:0]   q_reg    [2];
  logic [CNT_WIDTH-1:0]   hit_cnt_reg, miss_cnt_reg;

  rr_pick2 u_pick (
    .clk (clk),
    .rst (rst),
    .en  (state_reg == ARB),
    .req ({p1_req, p0_req}),
    .gnt (gnt)
  );

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_done   = done_reg[0];
  assign p1_done   = done_reg[1];
  assign p0_q      = q_reg[0];
  assign p1_q      = q_reg[1];
  assign c_address = addr_reg;
  assign c_din     = din_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, cache strobes and completion detect
  always_comb begin
    state_next = state_reg;
    c_rden     = 1'b0;
    c_wren     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      ARB: begin
        if (|gnt) state_next = ISSUE;
      end
      ISSUE: begin
        c_rden     = !wren_reg;
        c_wren     = wren_reg;
        state_next = BUSY;
      end
      BUSY: begin
        // The cache is still reporting idle on the first BUSY cycle
        if (!first_reg && c_idle) begin
          complete   = 1'b1;
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Capture the winner's payload and identity at grant time
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= 1'b0;
      wren_reg  <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
    end else if (|gnt) begin
      owner_reg <= gnt[1];
      wren_reg  <= gnt[1] ? p1_wren : p0_wren;
      addr_reg  <= gnt[1] ? p1_addr : p0_addr;
      din_reg   <= gnt[1] ? p1_din  : p0_din;
    end
  end

  // Marks the first BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      first_reg <= 1'b0;
    end else begin
      first_reg <= (state_reg == ISSUE);
    end
  end

  // Per-port done pulse and read-data hold register
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge clk) begin
      if (rst) begin
        done_reg[gi] <= 1'b0;
        q_reg[gi]    <= '0;
      end else begin
        done_reg[gi] <= complete && (owner_reg == 1'(gi));
        if (complete && (owner_reg == 1'(gi)) && !wren_reg) begin
          q_reg[gi] <= c_q;
        end
      end
    end
  end

  // Saturating hit/miss statistics, sampled on the command cycle
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      if (c_hit_miss) begin
        if (hit_cnt_reg != CNT_MAX) hit_cnt_reg <= hit_cnt_reg + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_reg != CNT_MAX) miss_cnt_reg <= miss_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

endmodule
